// File: rtl/ecall_io_ctrl.sv
// Environment-call I/O sequencer: stalls the core on ecall, then prints, reads
// switches/keyboard after a confirm-button press, or halts.
module ecall_io_ctrl #(
  parameter int TIMEOUT_CYC = 0,
  parameter int CNT_W       = 32
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ecall_valid,
  input  logic [31:0] ecall_code,
  input  logic [31:0] a0_data,
  input  logic [11:0] switch_data,
  input  logic [31:0] key_data,
  input  logic        conf_btn,
  output logic        cpu_en,
  output logic        rd_we,
  output logic [31:0] rd_data,
  output logic        seg_we,
  output logic        led_we,
  output logic [31:0] io_wdata,
  output logic        rd_timeout,
  output logic        halted,
  output logic        busy
);

  localparam logic [31:0] C_SEG     = 32'd1;
  localparam logic [31:0] C_LED     = 32'd2;
  localparam logic [31:0] C_RD_SW_S = 32'd5;
  localparam logic [31:0] C_RD_SW_Z = 32'd6;
  localparam logic [31:0] C_HALT    = 32'd10;
  localparam logic [31:0] C_RD_KEY  = 32'd12;

  typedef enum logic [1:0] {S_IDLE, S_WAIT_BTN, S_RESP, S_HALT} state_t;

  state_t           r_state;
  logic [31:0]      r_code;
  logic [31:0]      r_a0;
  logic [31:0]      r_rd_data;
  logic [CNT_W-1:0] r_cnt;
  logic             r_btn_q;
  logic             r_rd_we;
  logic             r_seg_we;
  logic             r_led_we;
  logic             r_timeout;

  logic             w_edge;
  logic             w_to_hit;
  logic [31:0]      w_src;

  assign w_edge   = conf_btn & ~r_btn_q;
  assign w_to_hit = (TIMEOUT_CYC != 0) && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    w_src = key_data;
    if (r_code == C_RD_SW_S)      w_src = {{20{switch_data[11]}}, switch_data};
    else if (r_code == C_RD_SW_Z) w_src = {20'd0, switch_data};
  end

  // Strobes are registered on the transition into RESP so they last exactly that one cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_code    <= '0;
      r_a0      <= '0;
      r_rd_data <= '0;
      r_cnt     <= '0;
      r_btn_q   <= 1'b0;
      r_rd_we   <= 1'b0;
      r_seg_we  <= 1'b0;
      r_led_we  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_btn_q   <= conf_btn;
      r_rd_we   <= 1'b0;
      r_seg_we  <= 1'b0;
      r_led_we  <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ecall_valid) begin
            r_code <= ecall_code;
            r_a0   <= a0_data;
            r_cnt  <= '0;
            case (ecall_code)
              C_RD_SW_S, C_RD_SW_Z, C_RD_KEY: r_state <= S_WAIT_BTN;
              C_HALT: r_state <= S_HALT;
              C_SEG: begin
                r_seg_we <= 1'b1;
                r_state  <= S_RESP;
              end
              C_LED: begin
                r_led_we <= 1'b1;
                r_state  <= S_RESP;
              end
              default: r_state <= S_RESP;
            endcase
          end
        end
        S_WAIT_BTN: begin
          if (w_edge) begin
            r_rd_data <= w_src;
            r_rd_we   <= 1'b1;
            r_state   <= S_RESP;
          end else if (w_to_hit) begin
            r_rd_data <= '0;
            r_rd_we   <= 1'b1;
            r_timeout <= 1'b1;
            r_state   <= S_RESP;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_RESP:  r_state <= S_IDLE;
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    cpu_en = 1'b0;
    if (rstn) begin
      if (r_state == S_IDLE)      cpu_en = ~ecall_valid;
      else if (r_state == S_RESP) cpu_en = 1'b1;
    end
  end

  assign rd_we      = r_rd_we;
  assign rd_data    = r_rd_data;
  assign seg_we     = r_seg_we;
  assign led_we     = r_led_we;
  assign io_wdata   = r_a0;
  assign rd_timeout = r_timeout;
  assign halted     = (r_state == S_HALT);
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_ecall_io_ctrl.sv
// Directed bench for ecall_io_ctrl: one instance without timeout, one with an 8-cycle timeout.
module tb_ecall_io_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        ecall_valid = 1'b0;
  logic [31:0] ecall_code = '0;
  logic [31:0] a0_data = '0;
  logic [11:0] switch_data = '0;
  logic [31:0] key_data = '0;
  logic        conf_btn = 1'b0;

  logic        cpu_en_0, rd_we_0, seg_we_0, led_we_0, rd_timeout_0, halted_0, busy_0;
  logic [31:0] rd_data_0, io_wdata_0;
  logic        cpu_en_8, rd_we_8, seg_we_8, led_we_8, rd_timeout_8, halted_8, busy_8;
  logic [31:0] rd_data_8, io_wdata_8;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ecall_io_ctrl dut0 (
    .clk(clk), .rstn(rstn), .ecall_valid(ecall_valid), .ecall_code(ecall_code),
    .a0_data(a0_data), .switch_data(switch_data), .key_data(key_data), .conf_btn(conf_btn),
    .cpu_en(cpu_en_0), .rd_we(rd_we_0), .rd_data(rd_data_0), .seg_we(seg_we_0),
    .led_we(led_we_0), .io_wdata(io_wdata_0), .rd_timeout(rd_timeout_0),
    .halted(halted_0), .busy(busy_0)
  );

  ecall_io_ctrl #(.TIMEOUT_CYC(8)) dut8 (
    .clk(clk), .rstn(rstn), .ecall_valid(ecall_valid), .ecall_code(ecall_code),
    .a0_data(a0_data), .switch_data(switch_data), .key_data(key_data), .conf_btn(conf_btn),
    .cpu_en(cpu_en_8), .rd_we(rd_we_8), .rd_data(rd_data_8), .seg_we(seg_we_8),
    .led_we(led_we_8), .io_wdata(io_wdata_8), .rd_timeout(rd_timeout_8),
    .halted(halted_8), .busy(busy_8)
  );

  typedef struct {
    logic [31:0] code;
    logic [31:0] a0;
    logic [11:0] sw;
    logic [31:0] key;
    logic        is_read;
    logic        e_seg;
    logic        e_led;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    ecall_valid = 1'b0;
    conf_btn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic start_call(input logic [31:0] code, input logic [31:0] a0,
                            input logic [11:0] sw, input logic [31:0] key, input logic btn);
    @(negedge clk);
    ecall_valid = 1'b1;
    ecall_code  = code;
    a0_data     = a0;
    switch_data = sw;
    key_data    = key;
    conf_btn    = btn;
  endtask

  initial begin
    int bad;

    vecs[0] = '{32'd1,  32'h0000_1234, 12'h000, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0};
    vecs[1] = '{32'd2,  32'hA5A5_0003, 12'h000, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0};
    vecs[2] = '{32'd6,  32'h0000_0066, 12'hFFE, 32'h0000_0055, 1'b1, 1'b0, 1'b0, 32'h0000_0FFE};
    vecs[3] = '{32'd12, 32'h0000_00CC, 12'hABC, 32'h0000_0017, 1'b1, 1'b0, 1'b0, 32'h0000_0017};
    vecs[4] = '{32'd99, 32'h0000_DEAD, 12'h123, 32'h0000_0044, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[5] = '{32'd5,  32'h0000_0055, 12'h7FF, 32'h0000_0099, 1'b1, 1'b0, 1'b0, 32'h0000_07FF};
    vecs[6] = '{32'd5,  32'h1357_9BDF, 12'h800, 32'h0000_0099, 1'b1, 1'b0, 1'b0, 32'hFFFF_F800};

    // Reset state
    @(negedge clk);
    #1;
    chk("rst_cpu_en", {31'd0, cpu_en_0}, 32'd0);
    chk("rst_busy", {31'd0, busy_0}, 32'd0);
    chk("rst_halted", {31'd0, halted_0}, 32'd0);
    chk("rst_strobes", {29'd0, rd_we_0, seg_we_0, led_we_0}, 32'd0);
    chk("rst_rd_data", rd_data_0, 32'd0);
    chk("rst_io_wdata", io_wdata_0, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("idle_cpu_en", {31'd0, cpu_en_0}, 32'd1);

    // Table-driven calls
    for (int i = 0; i < 7; i++) begin
      start_call(vecs[i].code, vecs[i].a0, vecs[i].sw, vecs[i].key, 1'b0);
      #1;
      chk($sformatf("v%0d_c0_cpu_en", i), {31'd0, cpu_en_0}, 32'd0);
      @(negedge clk);
      if (!vecs[i].is_read) begin
        chk($sformatf("v%0d_seg_we", i), {31'd0, seg_we_0}, {31'd0, vecs[i].e_seg});
        chk($sformatf("v%0d_led_we", i), {31'd0, led_we_0}, {31'd0, vecs[i].e_led});
        chk($sformatf("v%0d_rd_we", i), {31'd0, rd_we_0}, 32'd0);
        chk($sformatf("v%0d_cpu_en", i), {31'd0, cpu_en_0}, 32'd1);
        chk($sformatf("v%0d_io_wdata", i), io_wdata_0, vecs[i].a0);
        ecall_valid = 1'b0;
      end else begin
        chk($sformatf("v%0d_wait", i), {30'd0, cpu_en_0, rd_we_0}, 32'd0);
        chk($sformatf("v%0d_busy", i), {31'd0, busy_0}, 32'd1);
        conf_btn = 1'b1;
        @(negedge clk);
        chk($sformatf("v%0d_rd_we", i), {31'd0, rd_we_0}, 32'd1);
        chk($sformatf("v%0d_rd_data", i), rd_data_0, vecs[i].e_rd);
        chk($sformatf("v%0d_cpu_en", i), {31'd0, cpu_en_0}, 32'd1);
        chk($sformatf("v%0d_io_strb", i), {30'd0, seg_we_0, led_we_0}, 32'd0);
        chk($sformatf("v%0d_timeout", i), {31'd0, rd_timeout_0}, 32'd0);
        ecall_valid = 1'b0;
        conf_btn = 1'b0;
      end
      @(negedge clk);
      chk($sformatf("v%0d_idle", i), {28'd0, busy_0, rd_we_0, seg_we_0, led_we_0}, 32'd0);
      chk($sformatf("v%0d_idle_cpu_en", i), {31'd0, cpu_en_0}, 32'd1);
    end
    chk("rd_data_hold", rd_data_0, 32'hFFFF_F800);

    // Reset while waiting for the button
    start_call(32'd6, 32'h0000_0AAA, 12'h0F0, 32'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("rw_busy_before", {31'd0, busy_0}, 32'd1);
    rstn = 1'b0;
    #1;
    chk("rw_rd_data", rd_data_0, 32'd0);
    chk("rw_io_wdata", io_wdata_0, 32'd0);
    chk("rw_flags", {27'd0, busy_0, cpu_en_0, rd_we_0, halted_0, rd_timeout_0}, 32'd0);
    ecall_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rd_we_0 || busy_0) bad++;
      conf_btn = c[0];
    end
    conf_btn = 1'b0;
    chk("rw_no_stray_rd_we", bad, 0);

    // Signed switch read, button held on entry
    start_call(32'd5, 32'h0, 12'hFFE, 32'h0, 1'b1);
    bad = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (rd_we_0 || cpu_en_0 || !busy_0) bad++;
      conf_btn = (c < 10) || (c == 20);
    end
    chk("held_no_early_resp", bad, 0);
    @(negedge clk);
    chk("held_rd_we", {31'd0, rd_we_0}, 32'd1);
    chk("held_rd_data", rd_data_0, 32'hFFFF_FFFE);
    chk("held_cpu_en", {31'd0, cpu_en_0}, 32'd1);
    ecall_valid = 1'b0;
    conf_btn = 1'b0;
    @(negedge clk);
    chk("held_idle", {30'd0, busy_0, rd_we_0}, 32'd0);

    // Back-to-back print calls
    start_call(32'd1, 32'h0000_0011, 12'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("b2b_seg_c1", {30'd0, seg_we_0, led_we_0}, 32'd2);
    chk("b2b_io_c1", io_wdata_0, 32'h11);
    ecall_code = 32'd2;
    a0_data = 32'h0000_0022;
    @(negedge clk);
    chk("b2b_c2_quiet", {29'd0, seg_we_0, led_we_0, cpu_en_0}, 32'd0);
    @(negedge clk);
    chk("b2b_led_c3", {30'd0, seg_we_0, led_we_0}, 32'd1);
    chk("b2b_io_c3", io_wdata_0, 32'h22);
    ecall_valid = 1'b0;
    @(negedge clk);
    chk("b2b_idle", {31'd0, busy_0}, 32'd0);

    // Timeout instance: press on the timeout cycle wins, then a real timeout
    do_reset();
    start_call(32'd5, 32'h0, 12'h3C5, 32'h0, 1'b0);
    bad = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (rd_we_8 || cpu_en_8) bad++;
      if (c == 8) conf_btn = 1'b1;
    end
    chk("to_edge_wait", bad, 0);
    @(negedge clk);
    chk("to_edge_rd_we", {31'd0, rd_we_8}, 32'd1);
    chk("to_edge_rd_data", rd_data_8, 32'h0000_03C5);
    chk("to_edge_timeout", {31'd0, rd_timeout_8}, 32'd0);
    ecall_valid = 1'b0;
    conf_btn = 1'b0;
    @(negedge clk);
    start_call(32'd5, 32'h0, 12'h3C5, 32'h0, 1'b0);
    bad = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (rd_we_8 || cpu_en_8 || rd_timeout_8) bad++;
    end
    chk("to_wait", bad, 0);
    @(negedge clk);
    chk("to_rd_we", {31'd0, rd_we_8}, 32'd1);
    chk("to_rd_data", rd_data_8, 32'd0);
    chk("to_timeout", {31'd0, rd_timeout_8}, 32'd1);
    chk("to_cpu_en", {31'd0, cpu_en_8}, 32'd1);
    ecall_valid = 1'b0;
    @(negedge clk);
    chk("to_after", {29'd0, rd_timeout_8, rd_we_8, busy_8}, 32'd0);

    // Halt ignores everything until reset
    do_reset();
    start_call(32'd10, 32'h0, 12'h0, 32'h0, 1'b0);
    #1;
    chk("halt_c0_cpu_en", {31'd0, cpu_en_0}, 32'd0);
    @(negedge clk);
    chk("halt_c1", {30'd0, halted_0, cpu_en_0}, 32'd2);
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      ecall_valid = $urandom_range(0, 1) == 1;
      ecall_code = 32'd1;
      conf_btn = c[1];
      @(negedge clk);
      if (!halted_0 || cpu_en_0 || rd_we_0 || seg_we_0 || led_we_0) bad++;
    end
    chk("halt_100cyc", bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
